adc_sample_ctrl: RTL and testbench
==================================

ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 3: log2 of samples averaged per stored word (range 0..6).
REQ-002 The block SHALL have parameter ADDR_W, default 8: RAM address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: cycles without response_valid in ACQ before the run command is reissued.
REQ-004 The block SHALL have port clk  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-005 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 The block SHALL have port enable  in  1  level; 1 = acquire, 0 = stop.
REQ-007 The block SHALL have port pll_lock  in  1  ADC PLL locked.
REQ-008 The block SHALL have port csr_address  out  1  sequencer CSR address; always 0.
REQ-009 The block SHALL have port csr_write  out  1  one-cycle CSR write strobe.
REQ-010 The block SHALL have port csr_writedata  out  32  run word 32'h0000_0001 / stop word 32'h0000_0000.
REQ-011 The block SHALL have port response_valid  in  1  ADC sample strobe.
REQ-012 The block SHALL have port response_data  in  12  ADC sample.
REQ-013 The block SHALL have port ram_addr  out  ADDR_W  RAM write address.
REQ-014 The block SHALL have port ram_data  out  12  averaged sample.
REQ-015 The block SHALL have port ram_wren  out  1  one-cycle RAM write enable.
REQ-016 The block SHALL have port latest  out  12  most recent stored average.
REQ-017 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 The block SHALL have port error  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, LOCKWAIT, START, ACQ, STOP.
REQ-020 IDLE->LOCKWAIT SHALL occur when enable=1; LOCKWAIT->START when pll_lock=1; START->ACQ unconditionally after 1 cycle.
REQ-021 START SHALL drive csr_write=1 with csr_writedata = run word for exactly that one cycle.
REQ-022 In ACQ or LOCKWAIT, enable=0 or pll_lock=0 SHALL cause transition to STOP; STOP drives csr_write=1 with stop word for 1 cycle, then goes to IDLE.
REQ-023 When enable and pll_lock are both 0 in the same cycle, the block SHALL take one STOP transition only.
REQ-024 In ACQ, each response_valid SHALL add response_data to an accumulator of width 12+AVG_LOG2 and increment a sample counter.
REQ-025 On the valid that completes 2^AVG_LOG2 samples, the block SHALL register (acc+response_data)>>AVG_LOG2 into ram_data and latest, pulse ram_wren the following cycle, and clear the accumulator and counter.
REQ-026 A response_valid in the cycle ram_wren is high SHALL count as sample 1 of the next block; no sample SHALL be dropped.
REQ-027 ram_addr SHALL increment the cycle after each ram_wren and wrap from 2^ADDR_W-1 to 0.
REQ-028 On entry to STOP, the block SHALL discard the partial accumulator and counter; ram_addr and latest SHALL be retained.
REQ-029 A timeout counter SHALL clear on every response_valid and on entry to ACQ; on reaching TIMEOUT, the block SHALL set error=1 and go ACQ->START.
REQ-030 error SHALL clear only on rst or on entry to IDLE.
REQ-031 response_valid outside ACQ SHALL be ignored.

Reset
REQ-032 While rst=1, the block SHALL force state IDLE; accumulator, counters, ram_addr, ram_data, latest and error =0; csr_write, ram_wren, busy =0; csr_writedata =0.
REQ-033 Reset asserted mid-ACQ SHALL produce no stop-word write.

Verification
REQ-034 Reset: rst=1 for 2 cycles during ACQ -> all outputs 0 next cycle, no csr_write.
REQ-035 Lock gating: enable=1, pll_lock=0 for 10 cycles then 1 -> no csr_write before lock; one csr_write with data 1 and address 0, then busy=1 in ACQ.
REQ-036 Averaging: AVG_LOG2=2, valids 100,101,102,103 -> one ram_wren, ram_data=101, ram_addr=0, latest=101; next block writes at addr 1.
REQ-037 Wrap: ADDR_W=2, 5 complete blocks -> write addresses 0,1,2,3,0.
REQ-038 Stop mid-block: 2 of 4 samples then enable=0 -> one stop write (data 0), no ram_wren; re-enable -> new block starts at count 0, same ram_addr.
REQ-039 Timeout: TIMEOUT=16, no valid in ACQ -> error=1 and run word rewritten 16 cycles after ACQ entry; error stays 1 until enable=0 returns to IDLE.

Source files
------------

// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: starts and stops the ADC sequencer over its CSR, averages
// blocks of 2^AVG_LOG2 samples and streams the averages into a RAM.
module adc_sample_ctrl #(
  parameter int AVG_LOG2 = 3,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pll_lock,
  output logic              csr_address,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  input  logic              response_valid,
  input  logic [11:0]       response_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [11:0]       ram_data,
  output logic              ram_wren,
  output logic [11:0]       latest,
  output logic              busy,
  output logic              error
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOCKWAIT, S_START, S_ACQ, S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic               timeout_hit;
  logic               csr_write_q, csr_run_q, busy_q, error_q;
  logic [TO_W-1:0]    timeout_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_w, avg_w;
  logic               accept, blk_done, stop_entry, idle_entry;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [11:0]        ram_data_q, latest_q;
  logic               ram_wren_q;

  // Next-state logic; losing lock while still waiting for it just keeps waiting.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_LOCKWAIT;
      S_LOCKWAIT: begin
        if (!enable)       state_d = S_STOP;
        else if (pll_lock) state_d = S_START;
      end
      S_START:    state_d = S_ACQ;
      S_ACQ: begin
        if (!enable || !pll_lock) begin
          state_d = S_STOP;
        end else if (!response_valid && timeout_q == TO_LAST) begin
          state_d     = S_START;
          timeout_hit = 1'b1;
        end
      end
      S_STOP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign stop_entry = (state_d == S_STOP) && (state_q != S_STOP);
  assign idle_entry = (state_d == S_IDLE) && (state_q != S_IDLE);
  assign accept     = (state_q == S_ACQ) && response_valid;
  assign sum_w      = acc_q + ACC_W'(response_data);
  assign avg_w      = sum_w >> AVG_LOG2;
  assign blk_done   = accept && (cnt_q == LAST_CNT) && !stop_entry;

  // Accumulator next value: a stop discards the partial block outright.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (stop_entry) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST_CNT) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register and registered CSR/busy outputs (reset never emits a stop word).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      csr_write_q <= 1'b0;
      csr_run_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csr_write_q <= (state_d == S_START) || (state_d == S_STOP);
      csr_run_q   <= (state_d == S_START);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Sticky timeout flag, cleared only when the block returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst)              error_q <= 1'b0;
    else if (idle_entry)  error_q <= 1'b0;
    else if (timeout_hit) error_q <= 1'b1;
  end

  // Response watchdog: runs only in ACQ, restarted by every sample.
  always_ff @(posedge clk) begin
    if (rst)                              timeout_q <= '0;
    else if (state_q != S_ACQ || accept)  timeout_q <= '0;
    else                                  timeout_q <= timeout_q + 1'b1;
  end

  // Sample accumulator and block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // RAM write port: data registered with the completing sample, address bumps after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wren_q <= 1'b0;
      ram_data_q <= '0;
      latest_q   <= '0;
      ram_addr_q <= '0;
    end else begin
      ram_wren_q <= blk_done;
      if (blk_done) begin
        ram_data_q <= avg_w[11:0];
        latest_q   <= avg_w[11:0];
      end
      if (ram_wren_q) ram_addr_q <= ram_addr_q + 1'b1;
    end
  end

  assign csr_address   = 1'b0;
  assign csr_write     = csr_write_q;
  assign csr_writedata = {31'd0, csr_run_q};
  assign ram_addr      = ram_addr_q;
  assign ram_data      = ram_data_q;
  assign ram_wren      = ram_wren_q;
  assign latest        = latest_q;
  assign busy          = busy_q;
  assign error         = error_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with 4-sample averaging, a 4-entry RAM
// and a 16-cycle response timeout.
module tb_adc_sample_ctrl;
  localparam int AVG_LOG2 = 2;
  localparam int ADDR_W   = 2;
  localparam int TIMEOUT  = 16;

  logic              clk = 1'b0;
  logic              rst, enable, pll_lock;
  logic              csr_address, csr_write;
  logic [31:0]       csr_writedata;
  logic              response_valid;
  logic [11:0]       response_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_data, latest;
  logic              ram_wren, busy, error;

  int total = 0;
  int bad   = 0;
  int csr_pulses = 0;
  logic [31:0] last_csr_data = '0;
  int wr_addr_q[$];
  int wr_data_q[$];

  adc_sample_ctrl #(.AVG_LOG2(AVG_LOG2), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .response_valid(response_valid), .response_data(response_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .latest(latest), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Transaction log, sampled mid-cycle.
  always @(negedge clk) begin
    if (csr_write) begin
      csr_pulses++;
      last_csr_data = csr_writedata;
      $display("csr write addr=%0d data=%08h", csr_address, csr_writedata);
    end
    if (ram_wren) begin
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(int'(ram_data));
      $display("ram write addr=%0d data=%0d", ram_addr, ram_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    response_valid = 1'b1;
    response_data  = d;
    tick();
    response_valid = 1'b0;
  endtask

  task automatic enter_acq();
    enable = 1'b1; pll_lock = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    total++; if (csr_write !== 1'b0) begin bad++; $display("FAIL reset_csr_write got=%0d exp=0", csr_write); end
    total++; if (ram_addr !== 2'd0) begin bad++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0d exp=0", error); end
  endtask

  task automatic test_lock_gating();
    int c0;
    c0 = csr_pulses;
    enable = 1'b1; pll_lock = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    total++; if (csr_pulses !== c0) begin bad++; $display("FAIL lock_no_csr got=%0d exp=%0d", csr_pulses, c0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lock_wait_busy got=%0d exp=1", busy); end
    pll_lock = 1'b1;
    tick();
    total++; if (csr_write !== 1'b1) begin bad++; $display("FAIL lock_run_strobe got=%0d exp=1", csr_write); end
    total++; if (csr_writedata !== 32'h1) begin bad++; $display("FAIL lock_run_data got=%08h exp=00000001", csr_writedata); end
    total++; if (csr_address !== 1'b0) begin bad++; $display("FAIL lock_run_addr got=%0d exp=0", csr_address); end
    tick();
    total++; if (csr_write !== 1'b0) begin bad++; $display("FAIL lock_strobe_len got=%0d exp=0", csr_write); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lock_acq_busy got=%0d exp=1", busy); end
    total++; if (csr_pulses !== c0 + 1) begin bad++; $display("FAIL lock_one_csr got=%0d exp=%0d", csr_pulses, c0 + 1); end
  endtask

  // Two blocks back to back; the first sample of block 2 lands while ram_wren is high.
  task automatic test_averaging();
    logic [11:0] vals [8];
    vals = '{12'd100, 12'd101, 12'd102, 12'd103, 12'd8, 12'd8, 12'd8, 12'd12};
    for (int i = 0; i < 8; i++) begin
      response_valid = 1'b1;
      response_data  = vals[i];
      tick();
      if (i == 3) begin
        total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL avg1_wren got=%0d exp=1", ram_wren); end
        total++; if (ram_data !== 12'd101) begin bad++; $display("FAIL avg1_data got=%0d exp=101", ram_data); end
        total++; if (ram_addr !== 2'd0) begin bad++; $display("FAIL avg1_addr got=%0d exp=0", ram_addr); end
        total++; if (latest !== 12'd101) begin bad++; $display("FAIL avg1_latest got=%0d exp=101", latest); end
      end
      if (i == 4) begin
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL avg_wren_len got=%0d exp=0", ram_wren); end
        total++; if (ram_addr !== 2'd1) begin bad++; $display("FAIL avg_addr_inc got=%0d exp=1", ram_addr); end
      end
      if (i == 7) begin
        total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL avg2_wren got=%0d exp=1", ram_wren); end
        total++; if (ram_data !== 12'd9) begin bad++; $display("FAIL avg2_data got=%0d exp=9", ram_data); end
        total++; if (ram_addr !== 2'd1) begin bad++; $display("FAIL avg2_addr got=%0d exp=1", ram_addr); end
        total++; if (latest !== 12'd9) begin bad++; $display("FAIL avg2_latest got=%0d exp=9", latest); end
      end
    end
    response_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_acq();
    int c0;
    c0 = csr_pulses;
    rst = 1'b1;
    tick(); tick();
    total++; if ({csr_write, csr_writedata, csr_address} !== 34'd0) begin bad++; $display("FAIL rst_csr got=%0d/%08h exp=0/0", csr_write, csr_writedata); end
    total++; if ({ram_wren, ram_addr, ram_data, latest} !== 27'd0) begin bad++; $display("FAIL rst_ram got=%0d/%0d/%0d/%0d exp=0", ram_wren, ram_addr, ram_data, latest); end
    total++; if ({busy, error} !== 2'b00) begin bad++; $display("FAIL rst_status got=%0d/%0d exp=0/0", busy, error); end
    rst = 1'b0; enable = 1'b0; pll_lock = 1'b0;
    tick(); tick();
    total++; if (csr_pulses !== c0) begin bad++; $display("FAIL rst_no_stop_word got=%0d exp=%0d", csr_pulses, c0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%0d exp=0", busy); end
  endtask

  task automatic test_wrap();
    wr_addr_q.delete(); wr_data_q.delete();
    enter_acq();
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 4; i++) send(12'(50 + b));
    tick(); tick();
    total++; if (wr_addr_q.size() !== 5) begin bad++; $display("FAIL wrap_count got=%0d exp=5", wr_addr_q.size()); end
    for (int b = 0; b < 5 && b < wr_addr_q.size(); b++) begin
      total++; if (wr_addr_q[b] !== b % 4) begin bad++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", b, wr_addr_q[b], b % 4); end
      total++; if (wr_data_q[b] !== 50 + b) begin bad++; $display("FAIL wrap_data%0d got=%0d exp=%0d", b, wr_data_q[b], 50 + b); end
    end
  endtask

  task automatic test_stop_mid_block();
    int c0;
    wr_addr_q.delete(); wr_data_q.delete();
    c0 = csr_pulses;
    send(12'd200); send(12'd200);
    enable = 1'b0;
    tick();
    total++; if (csr_write !== 1'b1) begin bad++; $display("FAIL stop_strobe got=%0d exp=1", csr_write); end
    total++; if (csr_writedata !== 32'h0) begin bad++; $display("FAIL stop_data got=%08h exp=00000000", csr_writedata); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle got=%0d exp=0", busy); end
    // samples arriving while idle must not be counted
    for (int i = 0; i < 4; i++) send(12'd4000);
    tick();
    total++; if (csr_pulses !== c0 + 1) begin bad++; $display("FAIL stop_one_csr got=%0d exp=%0d", csr_pulses, c0 + 1); end
    total++; if (wr_addr_q.size() !== 0) begin bad++; $display("FAIL stop_no_wren got=%0d exp=0", wr_addr_q.size()); end
    total++; if (ram_addr !== 2'd1) begin bad++; $display("FAIL stop_addr_kept got=%0d exp=1", ram_addr); end
    total++; if (latest !== 12'd54) begin bad++; $display("FAIL stop_latest_kept got=%0d exp=54", latest); end
    enter_acq();
    send(12'd40); send(12'd40); send(12'd40); send(12'd44);
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL restart_wren got=%0d exp=1", ram_wren); end
    total++; if (ram_data !== 12'd41) begin bad++; $display("FAIL restart_data got=%0d exp=41", ram_data); end
    total++; if (ram_addr !== 2'd1) begin bad++; $display("FAIL restart_addr got=%0d exp=1", ram_addr); end
  endtask

  task automatic test_timeout();
    int early;
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1; pll_lock = 1'b1;
    tick(); tick(); tick();   // LOCKWAIT, START, first ACQ cycle
    early = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (csr_write !== 1'b0 || error !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", early); end
    tick();
    total++; if (csr_write !== 1'b1) begin bad++; $display("FAIL timeout_rerun got=%0d exp=1", csr_write); end
    total++; if (csr_writedata !== 32'h1) begin bad++; $display("FAIL timeout_data got=%08h exp=00000001", csr_writedata); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_error got=%0d exp=1", error); end
    tick(); tick(); tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0d exp=1", error); end
    enable = 1'b0;
    tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_stop_err got=%0d exp=1", error); end
    tick();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL timeout_idle_clear got=%0d exp=0", error); end
  endtask

  task automatic test_both_drop();
    int c0;
    enter_acq();
    c0 = csr_pulses;
    enable = 1'b0; pll_lock = 1'b0;
    tick(); tick(); tick(); tick();
    total++; if (csr_pulses !== c0 + 1) begin bad++; $display("FAIL both_drop_count got=%0d exp=%0d", csr_pulses, c0 + 1); end
    total++; if (last_csr_data !== 32'h0) begin bad++; $display("FAIL both_drop_data got=%08h exp=00000000", last_csr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_drop_idle got=%0d exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pll_lock = 1'b0;
    response_valid = 1'b0; response_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_lock_gating();
    test_averaging();
    test_reset_in_acq();
    test_wrap();
    test_stop_mid_block();
    test_timeout();
    test_both_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
